audio_mixer: RTL

//  Parametrised successor to the fixed 4-source audio mixer. Mixes CHANNELS unsigned sources with

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_mixer_sd_dac.sv | 28 ++
 rtl/audio_mixer.sv | 113 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio mixer slice.
package audio_pkg;

    localparam int unsigned CH_ULA      = 0;
    localparam int unsigned CH_SPECDRUM = 1;
    localparam int unsigned CH_PSG_A    = 2;
    localparam int unsigned CH_PSG_B    = 3;
    localparam int unsigned CH_PSG_C    = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_mixer_sd_dac.sv
// First-order sigma-delta DAC: the integrator carry is the output bitstream.
module sd_dac #(
    parameter int unsigned W = 10
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic [W-1:0] sample_i,
    output logic         bit_o
);

    logic [W-1:0] int_q, int_d;
    logic         carry_d;

    always_comb begin
        {carry_d, int_d} = {1'b0, int_q} + {1'b0, sample_i};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            int_q <= '0;
            bit_o <= 1'b0;
        end else begin
            int_q <= int_d;
            bit_o <= carry_d;
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: one MAC per side walks the channels, then the
// saturated sum is latched and fed to a sigma-delta DAC per side.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned VOLW     = 4,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned OUTW     = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ce,
    input  logic                       mute,
    input  logic [CHANNELS*WIDTH-1:0]  ch_data,
    input  logic [CHANNELS*VOLW-1:0]   ch_lvol,
    input  logic [CHANNELS*VOLW-1:0]   ch_rvol,
    output logic [OUTW-1:0]            sample_l,
    output logic [OUTW-1:0]            sample_r,
    output logic                       sample_v,
    output logic [1:0]                 audio
);

    localparam int unsigned PW  = WIDTH + VOLW;
    localparam int unsigned AW  = PW + clog2(CHANNELS + 1);
    localparam int unsigned SLW = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam logic [SLW-1:0] LAST = SLW'(CHANNELS - 1);

    logic [SLW-1:0]  slot_q, slot_d;
    logic [AW-1:0]   accl_q, accl_d, accr_q, accr_d;
    logic [OUTW-1:0] saml_q, saml_d, samr_q, samr_d;
    logic            v_q, v_d;

    logic [WIDTH-1:0] data_n;
    logic [VOLW-1:0]  lvol_n, rvol_n;
    logic [PW-1:0]    pl, pr;
    logic [AW-1:0]    suml, sumr;
    int unsigned      dbase, vbase;

    function automatic logic [OUTW-1:0] saturate(input logic [AW-1:0] s);
        logic [AW+OUTW-1:0] wide;
        wide = {{OUTW{1'b0}}, s >> SHIFT};
        return (|wide[AW+OUTW-1:OUTW]) ? '1 : wide[OUTW-1:0];
    endfunction

    always_comb begin
        dbase  = 32'(slot_q) * WIDTH;
        vbase  = 32'(slot_q) * VOLW;
        data_n = ch_data[dbase +: WIDTH];
        lvol_n = ch_lvol[vbase +: VOLW];
        rvol_n = ch_rvol[vbase +: VOLW];
        pl     = {{VOLW{1'b0}}, data_n} * {{WIDTH{1'b0}}, lvol_n};
        pr     = {{VOLW{1'b0}}, data_n} * {{WIDTH{1'b0}}, rvol_n};
        // slot 0 loads rather than adds, so a stale partial sum never leaks in
        suml   = ((slot_q == '0) ? '0 : accl_q) + {{(AW-PW){1'b0}}, pl};
        sumr   = ((slot_q == '0) ? '0 : accr_q) + {{(AW-PW){1'b0}}, pr};

        slot_d = slot_q;
        accl_d = accl_q;
        accr_d = accr_q;
        saml_d = saml_q;
        samr_d = samr_q;
        v_d    = 1'b0;
        if (ce) begin
            slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
            accl_d = suml;
            accr_d = sumr;
            if (slot_q == LAST) begin
                saml_d = mute ? '0 : saturate(suml);
                samr_d = mute ? '0 : saturate(sumr);
                v_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            accl_q <= '0;
            accr_q <= '0;
            saml_q <= '0;
            samr_q <= '0;
            v_q    <= 1'b0;
        end else begin
            slot_q <= slot_d;
            accl_q <= accl_d;
            accr_q <= accr_d;
            saml_q <= saml_d;
            samr_q <= samr_d;
            v_q    <= v_d;
        end
    end

    assign sample_l = saml_q;
    assign sample_r = samr_q;
    assign sample_v = v_q;

    sd_dac #(.W(OUTW)) u_dac_l (
        .clock_i  (clock),
        .reset_i  (reset),
        .sample_i (saml_q),
        .bit_o    (audio[0])
    );

    sd_dac #(.W(OUTW)) u_dac_r (
        .clock_i  (clock),
        .reset_i  (reset),
        .sample_i (samr_q),
        .bit_o    (audio[1])
    );

endmodule
